cmd_frame_rx: RTL and testbench

Parametrised host-command receiver sitting between the proto245 FIFO interface and the phase/calibration/enable logic. Parses framed commands from the RX byte stream with continuous byte-wise resynchronisation. Expands burst phase writes into per-channel write strobes, with a configurable phase width and an inter-byte watchdog. Returns a two-byte acknowledge per frame on the TX FIFO.

---
 rtl/cmd_frame_rx.sv | 239 +++++++++++++++++++++++
 tb/tb_cmd_frame_rx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: framed host-command receiver with burst phase writes and a per-frame ack.
// Optional feature macro: CMD_FRAME_RX_ACK_EN (ack states and TX writes built only when defined).
module cmd_frame_rx #(
    parameter int TX_FIFO_LOAD_W = 8,
    parameter int RX_FIFO_LOAD_W = 8,
    parameter int DATA_BYTES     = 4,
    parameter int ADDR_W         = 8,
    parameter int PHASE_W        = 8,
    parameter int NUM_CHANNELS   = 256,
    parameter int TIMEOUT_CYC    = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rxfifo_data,
    input  logic                      rxfifo_valid,
    input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
    input  logic                      rxfifo_empty,
    output logic                      rxfifo_rd,
    input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
    input  logic                      txfifo_full,
    output logic                      txfifo_wr,
    output logic [7:0]                txfifo_data,
    output logic [8*DATA_BYTES-1:0]   latest_data,
    output logic                      phase_wr,
    output logic [ADDR_W-1:0]         phase_addr,
    output logic [PHASE_W-1:0]        phase_data,
    output logic                      phase_calib_en,
    output logic                      global_enable,
    output logic                      debug_led,
    output logic                      frame_error
);
    // state | meaning
    // IDLE  | between frame bytes
    // REQ   | read a frame byte once the RX FIFO is not empty
    // WAIT  | wait for rxfifo_valid, shift byte into window
    // EVAL  | test window, execute a matched command
    // BREQ  | read a burst byte, watchdog running
    // BWAIT | wait for a burst byte, watchdog running
    // ACK0  | write 0xA5
    // ACK1  | write status
    localparam int DW   = 8 * DATA_BYTES;
    localparam int WW   = DW + 32;
    localparam int PB   = (PHASE_W + 7) / 8;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]     MAX_N   = 17'(NUM_CHANNELS);
    localparam logic [1:0]      PB_LAST = 2'(PB);
`ifdef CMD_FRAME_RX_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EVAL, BREQ, BWAIT, ACK0, ACK1} state_t;
    state_t state, state_nxt, done_state;

    logic [WW-1:0]      window;
    logic [DW-1:0]      payload;
    logic [DW+31:0]     payload_x;
    logic [15:0]        code, burst_n, pairs_left;
    logic               match, burst_bad, burst_ok, last_byte, wd_expired;
    logic [1:0]         byte_idx;
    logic [ADDR_W-1:0]  burst_addr;
    logic [PB*8-1:0]    phase_acc;
    logic [PB*8+7:0]    phase_shift;
    logic [WD_W-1:0]    wd_cnt;
    logic [7:0]         status;
    logic               tx_wr;
    logic [7:0]         tx_data;

    assign payload     = window[8 +: DW];
    assign payload_x   = {32'd0, payload};
    assign code        = window[DW+8 +: 16];
    assign burst_n     = payload[15:0];
    assign match       = (window[WW-1 -: 8] == 8'hAA) && (window[7:0] == 8'h55);
    assign burst_bad   = {1'b0, burst_n} > MAX_N;
    assign burst_ok    = (code == 16'h0002) && (burst_n != 16'd0) && !burst_bad;
    assign last_byte   = (byte_idx == PB_LAST);
    assign wd_expired  = (wd_cnt == '0);
    assign phase_shift = {phase_acc, rxfifo_data};
    assign done_state  = ACK_EN ? ACK0 : IDLE;

    logic unused;
    assign unused = ^{rxfifo_load, txfifo_load, payload_x, phase_shift[PB*8+7:PB*8]};

`ifdef CMD_FRAME_RX_ACK_EN
    assign txfifo_wr   = tx_wr;
    assign txfifo_data = tx_data;
`else
    assign txfifo_wr   = 1'b0;
    assign txfifo_data = 8'h00;
    logic unused_tx;
    assign unused_tx = ^{tx_wr, tx_data, status};
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rxfifo_rd = 1'b0;
        tx_wr     = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (!rxfifo_empty) begin
                    rxfifo_rd = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: if (rxfifo_valid) state_nxt = EVAL;
            EVAL: begin
                state_nxt = IDLE;
                if (match) state_nxt = burst_ok ? BREQ : done_state;
            end
            BREQ: begin
                if (wd_expired) state_nxt = done_state;
                else if (!rxfifo_empty) begin
                    rxfifo_rd = 1'b1;
                    state_nxt = BWAIT;
                end
            end
            BWAIT: begin
                if (rxfifo_valid)
                    state_nxt = (last_byte && pairs_left == 16'd1) ? done_state : BREQ;
                else if (wd_expired)
                    state_nxt = done_state;
            end
            ACK0: begin
                if (!txfifo_full) begin
                    tx_wr     = 1'b1;
                    tx_data   = 8'hA5;
                    state_nxt = ACK1;
                end
            end
            ACK1: begin
                if (!txfifo_full) begin
                    tx_wr     = 1'b1;
                    tx_data   = status;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window         <= '0;
            latest_data    <= '0;
            phase_wr       <= 1'b0;
            phase_addr     <= '0;
            phase_data     <= '0;
            phase_calib_en <= 1'b0;
            global_enable  <= 1'b1;
            debug_led      <= 1'b0;
            frame_error    <= 1'b0;
            status         <= 8'h00;
            pairs_left     <= '0;
            byte_idx       <= '0;
            burst_addr     <= '0;
            phase_acc      <= '0;
            wd_cnt         <= WD_LOAD;
        end else begin
            phase_wr       <= 1'b0;
            phase_calib_en <= 1'b0;
            case (state)
                WAIT: if (rxfifo_valid) window <= {window[WW-9:0], rxfifo_data};
                EVAL: begin
                    if (match) begin
                        window      <= '0;
                        latest_data <= payload;
                        status      <= 8'h00;
                        pairs_left  <= burst_n;
                        byte_idx    <= '0;
                        wd_cnt      <= WD_LOAD;
                        case (code)
                            16'h0001: begin
                                phase_wr   <= 1'b1;
                                phase_addr <= payload[ADDR_W-1:0];
                                phase_data <= payload_x[16 +: PHASE_W];
                            end
                            16'h0002: begin
                                if (burst_bad) begin
                                    status      <= 8'h02;
                                    frame_error <= 1'b1;
                                end
                            end
                            16'h0003: phase_calib_en <= 1'b1;
                            16'h0004: global_enable  <= payload[0];
                            16'h0005: frame_error    <= 1'b0;
                            16'h1ED0: debug_led      <= payload[0];
                            default: begin
                                status      <= 8'h01;
                                frame_error <= 1'b1;
                            end
                        endcase
                    end
                end
                BREQ: begin
                    if (wd_expired) begin
                        status      <= 8'h03;
                        frame_error <= 1'b1;
                        window      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
                end
                BWAIT: begin
                    if (rxfifo_valid) begin
                        wd_cnt <= WD_LOAD;
                        // byte 0 of a pair is the address, the rest build the phase MSB first
                        if (byte_idx == 2'd0) burst_addr <= rxfifo_data[ADDR_W-1:0];
                        else                  phase_acc  <= phase_shift[PB*8-1:0];
                        if (last_byte) begin
                            phase_wr   <= 1'b1;
                            phase_addr <= burst_addr;
                            phase_data <= phase_shift[PHASE_W-1:0];
                            byte_idx   <= '0;
                            pairs_left <= pairs_left - 16'd1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (wd_expired) begin
                        status      <= 8'h03;
                        frame_error <= 1'b1;
                        window      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_frame_rx.sv
// Scoreboard bench for cmd_frame_rx: RX FIFO model with random read latency, phase/TX monitors.
module tb_cmd_frame_rx;
    localparam int TIMEOUT = 60;
`ifdef CMD_FRAME_RX_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxfifo_data;
    logic        rxfifo_valid;
    logic [7:0]  rxfifo_load = 8'h00;
    logic        rxfifo_empty;
    logic        rxfifo_rd;
    logic [7:0]  txfifo_load = 8'h00;
    logic        txfifo_full;
    logic        txfifo_wr;
    logic [7:0]  txfifo_data;
    logic [31:0] latest_data;
    logic        phase_wr;
    logic [7:0]  phase_addr;
    logic [7:0]  phase_data;
    logic        phase_calib_en;
    logic        global_enable;
    logic        debug_led;
    logic        frame_error;

    cmd_frame_rx #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid), .rxfifo_load(rxfifo_load),
        .rxfifo_empty(rxfifo_empty), .rxfifo_rd(rxfifo_rd),
        .txfifo_load(txfifo_load), .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr),
        .txfifo_data(txfifo_data), .latest_data(latest_data),
        .phase_wr(phase_wr), .phase_addr(phase_addr), .phase_data(phase_data),
        .phase_calib_en(phase_calib_en), .global_enable(global_enable),
        .debug_led(debug_led), .frame_error(frame_error)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         lat;
    } ph_t;

    ph_t        ph_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_q[$];
    int  n_pass = 0, n_total = 0;
    int  cyc = 0, last_valid_cyc = 0, calib_cnt = 0, rd_delay = 0;
    bit  rd_pending = 1'b0;
    logic [7:0] rd_byte;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : rx_model
        rxfifo_valid = 1'b0;
        rxfifo_data  = 8'h00;
        rxfifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            rxfifo_valid = 1'b0;
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    rxfifo_valid   = 1'b1;
                    rxfifo_data    = rd_byte;
                    rd_pending     = 1'b0;
                    last_valid_cyc = cyc;
                end else begin
                    rd_delay--;
                end
            end
            if (rxfifo_rd === 1'b1 && rx_q.size() != 0) begin
                rd_byte    = rx_q.pop_front();
                rd_pending = 1'b1;
                rd_delay   = $urandom_range(0, 2);
            end
            @(posedge clk);
            #1 rxfifo_empty = (rx_q.size() == 0);
        end
    end

    initial begin : out_mon
        ph_t e;
        logic [7:0] t;
        forever begin
            @(negedge clk);
            if (phase_calib_en === 1'b1) calib_cnt++;
            if (phase_wr === 1'b1) begin
                n_total++;
                if (ph_exp.size() == 0) begin
                    $display("FAIL phase_wr_unexpected: got addr %0h data %0h, required no write", phase_addr, phase_data);
                end else begin
                    e = ph_exp.pop_front();
                    if (phase_addr !== e.addr || phase_data !== e.data || (cyc - last_valid_cyc) != e.lat)
                        $display("FAIL phase_wr: got addr %0h data %0h lat %0d, required addr %0h data %0h lat %0d",
                                 phase_addr, phase_data, cyc - last_valid_cyc, e.addr, e.data, e.lat);
                    else n_pass++;
                end
            end
            if (txfifo_wr === 1'b1) begin
                n_total++;
                if (txfifo_full !== 1'b0) begin
                    $display("FAIL tx_wr_while_full: got wr with full=%b, required no write", txfifo_full);
                end else if (tx_exp.size() == 0) begin
                    $display("FAIL tx_unexpected: got %0h, required no write", txfifo_data);
                end else begin
                    t = tx_exp.pop_front();
                    if (txfifo_data !== t) $display("FAIL tx_data: got %0h, required %0h", txfifo_data, t);
                    else n_pass++;
                end
            end
        end
    end

    initial begin : global_guard
        #3_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "global timeout");
    end

    task automatic push_frame(input logic [15:0] code, input logic [31:0] payload);
        rx_q.push_back(8'hAA);
        rx_q.push_back(code[15:8]);
        rx_q.push_back(code[7:0]);
        for (int i = 3; i >= 0; i--) rx_q.push_back(payload[i*8 +: 8]);
        rx_q.push_back(8'h55);
    endtask

    task automatic push_ack(input logic [7:0] st);
        if (ACK_EN) begin
            tx_exp.push_back(8'hA5);
            tx_exp.push_back(st);
        end
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (rx_q.size() != 0 || rd_pending || rxfifo_valid || ph_exp.size() != 0 || tx_exp.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                ok = 1'b0;
                ph_exp.delete();
                tx_exp.delete();
                break;
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_rx_empty(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (rx_q.size() != 0 || rd_pending || rxfifo_valid) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin ok = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        txfifo_full = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (global_enable !== 1'b1) $display("FAIL rst_global_enable: got %b, required 1", global_enable); else n_pass++;
        n_total++; if (frame_error !== 1'b0) $display("FAIL rst_frame_error: got %b, required 0", frame_error); else n_pass++;
        n_total++; if (latest_data !== 32'h0) $display("FAIL rst_latest_data: got %0h, required 0", latest_data); else n_pass++;
        n_total++; if (phase_wr !== 1'b0) $display("FAIL rst_phase_wr: got %b, required 0", phase_wr); else n_pass++;
        n_total++; if (phase_addr !== 8'h0 || phase_data !== 8'h0) $display("FAIL rst_phase_bus: got %0h/%0h, required 0/0", phase_addr, phase_data); else n_pass++;
        n_total++; if (debug_led !== 1'b0 || phase_calib_en !== 1'b0) $display("FAIL rst_led_calib: got %b/%b, required 0/0", debug_led, phase_calib_en); else n_pass++;
        n_total++; if (txfifo_wr !== 1'b0 || rxfifo_rd !== 1'b0) $display("FAIL rst_strobes: got %b/%b, required 0/0", txfifo_wr, rxfifo_rd); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_phase_write;
        bit ok;
        push_frame(16'h0001, 32'h002A0013);
        ph_exp.push_back('{addr: 8'h13, data: 8'h2A, lat: 2});
        push_ack(8'h00);
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL pw_drain: got timeout, required outputs"); else n_pass++;
        n_total++; if (latest_data !== 32'h002A0013) $display("FAIL pw_latest: got %0h, required 002a0013", latest_data); else n_pass++;
        n_total++; if (frame_error !== 1'b0) $display("FAIL pw_error: got %b, required 0", frame_error); else n_pass++;
    endtask

    task automatic test_resync;
        bit ok;
        n_total++; if (global_enable !== 1'b1) $display("FAIL rs_enable_before: got %b, required 1", global_enable); else n_pass++;
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        push_frame(16'h0004, 32'h00000000);
        push_ack(8'h00);
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rs_drain: got timeout, required outputs"); else n_pass++;
        n_total++; if (global_enable !== 1'b0) $display("FAIL rs_enable_after: got %b, required 0", global_enable); else n_pass++;
        n_total++; if (frame_error !== 1'b0) $display("FAIL rs_error: got %b, required 0", frame_error); else n_pass++;
    endtask

    task automatic test_burst;
        bit ok;
        logic [7:0] pairs [6];
        pairs = '{8'h05, 8'h10, 8'h06, 8'h20, 8'h07, 8'h30};
        push_frame(16'h0002, 32'h00000003);
        for (int i = 0; i < 6; i++) rx_q.push_back(pairs[i]);
        for (int i = 0; i < 3; i++) ph_exp.push_back('{addr: pairs[2*i], data: pairs[2*i+1], lat: 1});
        push_ack(8'h00);
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL burst_drain: got timeout, required outputs"); else n_pass++;
        n_total++; if (latest_data !== 32'h3) $display("FAIL burst_latest: got %0h, required 3", latest_data); else n_pass++;
        n_total++; if (frame_error !== 1'b0) $display("FAIL burst_error: got %b, required 0", frame_error); else n_pass++;
    endtask

    task automatic test_timeout;
        bit ok;
        push_frame(16'h0002, 32'h00000002);
        rx_q.push_back(8'h08);
        rx_q.push_back(8'h44);
        ph_exp.push_back('{addr: 8'h08, data: 8'h44, lat: 1});
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL to_drain: got timeout, required first pair"); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (frame_error !== 1'b0) $display("FAIL to_error_early: got %b, required 0", frame_error); else n_pass++;
        push_ack(8'h03);
        repeat (TIMEOUT + 20) @(negedge clk);
        n_total++; if (frame_error !== 1'b1) $display("FAIL to_error_set: got %b, required 1", frame_error); else n_pass++;
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL to_ack: got timeout, required ack"); else n_pass++;
        push_frame(16'h0005, 32'h00000000);
        push_ack(8'h00);
        wait_drain(ok);
        n_total++; if (frame_error !== 1'b0) $display("FAIL to_error_clear: got %b, required 0", frame_error); else n_pass++;
    endtask

    task automatic test_unknown_full;
        bit ok;
        int exp_tx, exp_rx;
        txfifo_full = 1'b1;
        push_frame(16'h00FF, 32'hDEADBEEF);
        push_ack(8'h01);
        wait_rx_empty(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL uk_rx: got timeout, required frame consumed"); else n_pass++;
        rx_q.push_back(8'h77);
        repeat (20) @(negedge clk);
        exp_tx = ACK_EN ? 2 : 0;
        exp_rx = ACK_EN ? 1 : 0;
        n_total++; if (tx_exp.size() != exp_tx) $display("FAIL uk_hold_tx: got %0d pending, required %0d", tx_exp.size(), exp_tx); else n_pass++;
        n_total++; if (rx_q.size() != exp_rx) $display("FAIL uk_rx_stall: got %0d queued, required %0d", rx_q.size(), exp_rx); else n_pass++;
        txfifo_full = 1'b0;
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL uk_drain: got timeout, required ack"); else n_pass++;
        n_total++; if (frame_error !== 1'b1) $display("FAIL uk_error: got %b, required 1", frame_error); else n_pass++;
        n_total++; if (latest_data !== 32'hDEADBEEF) $display("FAIL uk_latest: got %0h, required deadbeef", latest_data); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int base;
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h03);
        rx_q.push_back(8'h00);
        wait_rx_empty(ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_total++; if (frame_error !== 1'b0) $display("FAIL rm_error: got %b, required 0", frame_error); else n_pass++;
        n_total++; if (global_enable !== 1'b1) $display("FAIL rm_enable: got %b, required 1", global_enable); else n_pass++;
        base = calib_cnt;
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h55);
        push_frame(16'h0003, 32'h00000000);
        push_ack(8'h00);
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rm_drain: got timeout, required ack"); else n_pass++;
        n_total++; if (calib_cnt - base != 1) $display("FAIL rm_calib: got %0d pulses, required 1", calib_cnt - base); else n_pass++;
    endtask

    task automatic test_codes;
        bit ok;
        push_frame(16'h1ED0, 32'h00000001);
        push_ack(8'h00);
        push_frame(16'h0004, 32'h00000000);
        push_ack(8'h00);
        push_frame(16'h0002, 32'h00000000);
        push_ack(8'h00);
        wait_drain(ok);
        n_total++; if (debug_led !== 1'b1) $display("FAIL cd_led: got %b, required 1", debug_led); else n_pass++;
        n_total++; if (global_enable !== 1'b0) $display("FAIL cd_enable: got %b, required 0", global_enable); else n_pass++;
        n_total++; if (frame_error !== 1'b0) $display("FAIL cd_zero_burst_error: got %b, required 0", frame_error); else n_pass++;
        push_frame(16'h0002, 32'h00000101);
        push_ack(8'h02);
        wait_drain(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL cd_drain: got timeout, required ack"); else n_pass++;
        n_total++; if (frame_error !== 1'b1) $display("FAIL cd_range_error: got %b, required 1", frame_error); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        txfifo_full = 1'b0;
        test_reset();
        test_phase_write();
        test_resync();
        test_burst();
        test_timeout();
        test_unknown_full();
        test_reset_mid_frame();
        test_codes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
